// File: rtl/half_duplex_spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : half_duplex_spi_sequencer
// Description : Buffers register-access commands, launches them one at a time
//               into a half-duplex SPI master with a start/busy handshake,
//               enforces an idle gap, collects read data into a response FIFO
//               and flags a master that never goes busy.
// Revision    : 1.0 - initial release
// ============================================================================
module half_duplex_spi_sequencer #(
    parameter int DATA_WIDTH            = 32,
    parameter int TRANSACTION_LEN_WIDTH = 6,
    parameter int FIFO_DEPTH_LOG2       = 2,
    parameter int GAP_CYCLES            = 4,
    parameter int BUSY_TIMEOUT          = 16
) (
    input  logic                             fabric_clk,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [TRANSACTION_LEN_WIDTH-1:0] cmd_length,
    input  logic [DATA_WIDTH-1:0]            cmd_data,
    input  logic [DATA_WIDTH-1:0]            cmd_rw_mask,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic [TRANSACTION_LEN_WIDTH-1:0] spi_length,
    output logic [DATA_WIDTH-1:0]            spi_data,
    output logic [DATA_WIDTH-1:0]            spi_rw_mask,
    output logic                             spi_start,
    input  logic                             spi_busy,
    input  logic [DATA_WIDTH-1:0]            spi_read_data,
    output logic                             idle,
    output logic                             timeout_err,
    input  logic                             clear_err
);

    localparam int c_depth  = 1 << FIFO_DEPTH_LOG2;
    localparam int c_cmd_w  = TRANSACTION_LEN_WIDTH + 2 * DATA_WIDTH;
    localparam int c_tmr_w  = $clog2(BUSY_TIMEOUT + 1);
    localparam int c_gap_w  = $clog2(GAP_CYCLES + 1);
    // The LAUNCH cycle counts as the first waited cycle, so the wait counter
    // starts one short and the flag lands BUSY_TIMEOUT cycles after LAUNCH.
    localparam logic [c_tmr_w-1:0] c_tmr_load = c_tmr_w'(BUSY_TIMEOUT - 1);
    localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [c_cmd_w-1:0]         r_cmd_mem [c_depth];
    logic [FIFO_DEPTH_LOG2:0]   r_cmd_wr;
    logic [FIFO_DEPTH_LOG2:0]   r_cmd_rd;
    logic [DATA_WIDTH-1:0]      r_rsp_mem [c_depth];
    logic [FIFO_DEPTH_LOG2:0]   r_rsp_wr;
    logic [FIFO_DEPTH_LOG2:0]   r_rsp_rd;

    logic [TRANSACTION_LEN_WIDTH-1:0] r_spi_length;
    logic [DATA_WIDTH-1:0]            r_spi_data;
    logic [DATA_WIDTH-1:0]            r_spi_rw_mask;
    logic [c_tmr_w-1:0]               r_tmr;
    logic [c_gap_w-1:0]               r_gap;
    logic                             r_timeout_err;

    logic                             w_cmd_empty;
    logic                             w_cmd_full;
    logic                             w_cmd_push;
    logic                             w_cmd_pop;
    logic [c_cmd_w-1:0]               w_cmd_head;
    logic [TRANSACTION_LEN_WIDTH-1:0] w_head_len;
    logic                             w_rsp_empty;
    logic                             w_rsp_full;
    logic                             w_rsp_push;
    logic                             w_rsp_pop;
    logic                             w_spi_start;
    logic                             w_timeout_set;

    // Pointer-based full/empty: an extra MSB distinguishes full from empty.
    assign w_cmd_empty = (r_cmd_wr == r_cmd_rd);
    assign w_cmd_full  = (r_cmd_wr[FIFO_DEPTH_LOG2] != r_cmd_rd[FIFO_DEPTH_LOG2]) &&
                         (r_cmd_wr[FIFO_DEPTH_LOG2-1:0] == r_cmd_rd[FIFO_DEPTH_LOG2-1:0]);
    assign w_rsp_empty = (r_rsp_wr == r_rsp_rd);
    assign w_rsp_full  = (r_rsp_wr[FIFO_DEPTH_LOG2] != r_rsp_rd[FIFO_DEPTH_LOG2]) &&
                         (r_rsp_wr[FIFO_DEPTH_LOG2-1:0] == r_rsp_rd[FIFO_DEPTH_LOG2-1:0]);

    assign w_cmd_push = cmd_valid && !w_cmd_full;
    assign w_rsp_pop  = !w_rsp_empty && rsp_ready;
    assign w_cmd_head = r_cmd_mem[r_cmd_rd[FIFO_DEPTH_LOG2-1:0]];
    assign w_head_len = w_cmd_head[c_cmd_w-1 -: TRANSACTION_LEN_WIDTH];

    assign cmd_ready   = !w_cmd_full;
    assign rsp_valid   = !w_rsp_empty;
    // Forced to zero when empty so no stale word is ever visible.
    assign rsp_data    = w_rsp_empty ? '0 : r_rsp_mem[r_rsp_rd[FIFO_DEPTH_LOG2-1:0]];
    assign spi_length  = r_spi_length;
    assign spi_data    = r_spi_data;
    assign spi_rw_mask = r_spi_rw_mask;
    assign spi_start   = w_spi_start;
    assign idle        = (r_state == ST_IDLE) && w_cmd_empty;
    assign timeout_err = r_timeout_err;

    // Storage arrays carry no reset; validity is tracked by the pointers.
    always_ff @(posedge fabric_clk) begin
        if (w_cmd_push) begin
            r_cmd_mem[r_cmd_wr[FIFO_DEPTH_LOG2-1:0]] <= {cmd_length, cmd_data, cmd_rw_mask};
        end
        if (w_rsp_push) begin
            r_rsp_mem[r_rsp_wr[FIFO_DEPTH_LOG2-1:0]] <= spi_read_data;
        end
    end

    // FIFO pointers advance on push/pop and wrap naturally.
    always_ff @(posedge fabric_clk) begin
        if (reset) begin
            r_cmd_wr <= '0;
            r_cmd_rd <= '0;
            r_rsp_wr <= '0;
            r_rsp_rd <= '0;
        end else begin
            if (w_cmd_push) r_cmd_wr <= r_cmd_wr + 1'b1;
            if (w_cmd_pop)  r_cmd_rd <= r_cmd_rd + 1'b1;
            if (w_rsp_push) r_rsp_wr <= r_rsp_wr + 1'b1;
            if (w_rsp_pop)  r_rsp_rd <= r_rsp_rd + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge fabric_clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state and per-state strobes.
    always_comb begin
        w_next_state  = r_state;
        w_cmd_pop     = 1'b0;
        w_rsp_push    = 1'b0;
        w_spi_start   = 1'b0;
        w_timeout_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_cmd_empty && !w_rsp_full) begin
                    w_cmd_pop = 1'b1;
                    // Zero-length commands are dropped without a launch.
                    if (w_head_len != '0) w_next_state = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_spi_start  = 1'b1;
                w_next_state = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (spi_busy) begin
                    w_next_state = ST_WAIT_DONE;
                end else if (r_tmr == c_tmr_w'(1)) begin
                    w_timeout_set = 1'b1;
                    w_next_state  = ST_GAP;
                end
            end
            ST_WAIT_DONE: begin
                if (!spi_busy) begin
                    w_rsp_push   = 1'b1;
                    w_next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap == '0) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Transaction fields, wait/gap counters and the sticky timeout flag.
    always_ff @(posedge fabric_clk) begin
        if (reset) begin
            r_spi_length  <= '0;
            r_spi_data    <= '0;
            r_spi_rw_mask <= '0;
            r_tmr         <= '0;
            r_gap         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_cmd_pop) begin
                {r_spi_length, r_spi_data, r_spi_rw_mask} <= w_cmd_head;
            end
            if (r_state == ST_LAUNCH) begin
                r_tmr <= c_tmr_load;
            end else if (r_state == ST_WAIT_BUSY && !spi_busy) begin
                r_tmr <= r_tmr - 1'b1;
            end
            if (r_state != ST_GAP && w_next_state == ST_GAP) begin
                r_gap <= c_gap_load;
            end else if (r_state == ST_GAP) begin
                r_gap <= r_gap - 1'b1;
            end
            // Setting wins over a same-cycle clear.
            if (w_timeout_set)  r_timeout_err <= 1'b1;
            else if (clear_err) r_timeout_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_half_duplex_spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_half_duplex_spi_sequencer
// Description : Self-checking bench: directed steps with random fields, a
//               behavioural SPI master and an in-order command/response model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_half_duplex_spi_sequencer;

    localparam int DW  = 32;
    localparam int LW  = 6;
    localparam int GAP = 4;
    localparam int TO  = 16;

    logic          fabric_clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [LW-1:0] cmd_length = '0;
    logic [DW-1:0] cmd_data = '0;
    logic [DW-1:0] cmd_rw_mask = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic [LW-1:0] spi_length;
    logic [DW-1:0] spi_data;
    logic [DW-1:0] spi_rw_mask;
    logic          spi_start;
    logic          spi_busy = 1'b0;
    logic [DW-1:0] spi_read_data = '0;
    logic          idle;
    logic          timeout_err;
    logic          clear_err = 1'b0;

    half_duplex_spi_sequencer #(
        .DATA_WIDTH(DW), .TRANSACTION_LEN_WIDTH(LW), .FIFO_DEPTH_LOG2(2),
        .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TO)
    ) dut (
        .fabric_clk(fabric_clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_length(cmd_length),
        .cmd_data(cmd_data), .cmd_rw_mask(cmd_rw_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .spi_length(spi_length), .spi_data(spi_data), .spi_rw_mask(spi_rw_mask),
        .spi_start(spi_start), .spi_busy(spi_busy), .spi_read_data(spi_read_data),
        .idle(idle), .timeout_err(timeout_err), .clear_err(clear_err)
    );

    always #5 fabric_clk = ~fabric_clk;

    typedef struct {
        logic [LW-1:0] len;
        logic [DW-1:0] data;
        logic [DW-1:0] mask;
        int            cyc;   // accept cycle (expected) or start cycle (observed)
        int            sp;    // start cycle minus last busy-fall cycle
    } cmd_t;

    cmd_t          exp_launch[$];
    cmd_t          act_launch[$];
    logic [DW-1:0] exp_rsp[$];
    logic [DW-1:0] act_rsp[$];
    logic [DW-1:0] rd_q[$];

    int   cyc = 0;
    int   last_fall = -1000;
    int   err_rise = -1;
    int   m_cnt = 0;
    int   m_busy_len = 5;
    bit   m_never = 1'b0;
    logic prev_err = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge fabric_clk) cyc <= cyc + 1;

    // Behavioural master plus output monitors, sampled just after the falling edge.
    always @(negedge fabric_clk) begin
        cmd_t          a;
        logic [DW-1:0] v;
        #1;
        if (reset) begin
            spi_busy = 1'b0;
            m_cnt    = 0;
            prev_err = 1'b0;
        end else begin
            if (rsp_valid && rsp_ready) act_rsp.push_back(rsp_data);
            if (timeout_err && !prev_err) err_rise = cyc;
            prev_err = timeout_err;
            if (spi_start) begin
                a.len = spi_length; a.data = spi_data; a.mask = spi_rw_mask;
                a.cyc = cyc; a.sp = cyc - last_fall;
                act_launch.push_back(a);
                if (!m_never) begin
                    spi_busy = 1'b1;
                    m_cnt    = m_busy_len;
                end
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    if (rd_q.size() > 0) v = rd_q.pop_front();
                    else                 v = $urandom;
                    spi_read_data = v;
                    spi_busy      = 1'b0;
                    exp_rsp.push_back(v);
                    last_fall = cyc;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic push_cmd(input logic [LW-1:0] len, input logic [DW-1:0] data,
                            input logic [DW-1:0] mask);
        cmd_t e;
        int   i = 0;
        cmd_valid = 1'b1; cmd_length = len; cmd_data = data; cmd_rw_mask = mask;
        while (!cmd_ready && i < 500) begin
            @(negedge fabric_clk);
            i++;
        end
        chk("push_ready", cmd_ready, 1);
        e.len = len; e.data = data; e.mask = mask; e.cyc = cyc; e.sp = 0;
        if (len != 0) exp_launch.push_back(e);
        @(negedge fabric_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_launches(input int n, input string tag);
        int i = 0;
        while (act_launch.size() < n && i < 500) begin
            @(negedge fabric_clk);
            i++;
        end
        chk({tag, "_launches"}, act_launch.size(), n);
    endtask

    task automatic settle(input string tag);
        int i = 0;
        bit ok;
        ok = 1'b0;
        while (!ok && i < 3000) begin
            @(negedge fabric_clk);
            i++;
            ok = idle && !spi_busy && act_launch.size() == exp_launch.size()
                 && act_rsp.size() == exp_rsp.size();
        end
        chk({tag, "_settle"}, ok, 1);
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_nlaunch"}, act_launch.size(), exp_launch.size());
        for (int i = 0; i < act_launch.size() && i < exp_launch.size(); i++) begin
            chk($sformatf("%s_len%0d", tag, i),  act_launch[i].len,  exp_launch[i].len);
            chk($sformatf("%s_data%0d", tag, i), act_launch[i].data, exp_launch[i].data);
            chk($sformatf("%s_mask%0d", tag, i), act_launch[i].mask, exp_launch[i].mask);
        end
        chk({tag, "_nrsp"}, act_rsp.size(), exp_rsp.size());
        for (int i = 0; i < act_rsp.size() && i < exp_rsp.size(); i++) begin
            chk($sformatf("%s_rsp%0d", tag, i), act_rsp[i], exp_rsp[i]);
        end
        exp_launch.delete(); act_launch.delete(); exp_rsp.delete(); act_rsp.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_spi_length"}, spi_length, 0);
        chk({tag, "_spi_data"}, spi_data, 0);
        chk({tag, "_spi_rw_mask"}, spi_rw_mask, 0);
        chk({tag, "_spi_start"}, spi_start, 0);
        chk({tag, "_idle"}, idle, 1);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            s;
        int            i;
        logic [LW-1:0] l;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge fabric_clk);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge fabric_clk);
        rsp_ready = 1'b1;

        // Single write: latency, fields, one response, idle after the gap
        m_busy_len = 30;
        push_cmd(6'd24, 32'h00AB_CDEF, 32'h0);
        wait_launches(1, "t1");
        if (act_launch.size() > 0 && exp_launch.size() > 0)
            chk("t1_latency", act_launch[0].cyc - exp_launch[0].cyc, 2);
        chk("t1_spi_length", spi_length, 24);
        chk("t1_spi_data", spi_data, 32'h00AB_CDEF);
        chk("t1_spi_rw_mask", spi_rw_mask, 0);
        i = 0;
        while (!idle && i < 200) begin
            @(negedge fabric_clk);
            i++;
        end
        chk("t1_idle_after_gap", cyc - last_fall, GAP + 1);
        settle("t1");
        compare_all("t1");

        // Five back-to-back commands: backpressure and launch spacing
        m_busy_len = $urandom_range(2, 8);
        for (int k = 0; k < 5; k++) push_cmd(LW'($urandom_range(1, 63)), $urandom, $urandom);
        chk("t2_cmd_ready_full", cmd_ready, 0);
        settle("t2");
        for (int k = 1; k < act_launch.size(); k++)
            chk($sformatf("t2_spacing%0d", k), act_launch[k].sp, GAP + 2);
        compare_all("t2");

        // Reads with the consumer stalled: response FIFO fills, 5th launch waits
        rsp_ready = 1'b0;
        m_busy_len = $urandom_range(2, 6);
        for (int k = 0; k < 5; k++) rd_q.push_back(32'h11 * (k + 1));
        for (int k = 0; k < 5; k++) push_cmd(LW'($urandom_range(1, 63)), $urandom, 32'hFFFF_FFFF);
        wait_launches(4, "t3a");
        repeat (40) @(negedge fabric_clk);
        chk("t3_stalled_launches", act_launch.size(), 4);
        chk("t3_rsp_valid", rsp_valid, 1);
        chk("t3_rsp_head", rsp_data, 32'h11);
        chk("t3_idle_pending", idle, 0);
        rsp_ready = 1'b1;
        @(negedge fabric_clk);
        rsp_ready = 1'b0;
        wait_launches(5, "t3b");
        rsp_ready = 1'b1;
        settle("t3");
        for (int k = 0; k < act_rsp.size(); k++)
            chk($sformatf("t3_rsp_order%0d", k), act_rsp[k], 32'h11 * (k + 1));
        compare_all("t3");

        // Master never goes busy: timeout timing, no response, fields held
        m_never = 1'b1;
        err_rise = -1;
        l = LW'($urandom_range(1, 63));
        push_cmd(l, $urandom, $urandom);
        wait_launches(1, "t4a");
        s = act_launch.size() > 0 ? act_launch[0].cyc : 0;
        i = 0;
        while (err_rise < 0 && i < 100) begin
            @(negedge fabric_clk);
            i++;
        end
        chk("t4_timeout_delay", err_rise - s, TO);
        chk("t4_timeout_err", timeout_err, 1);
        settle("t4a");
        chk("t4_no_rsp_valid", rsp_valid, 0);
        chk("t4_fields_held", spi_length, l);
        compare_all("t4a");
        m_never = 1'b0;
        push_cmd(LW'($urandom_range(1, 63)), $urandom, $urandom);
        settle("t4b");
        chk("t4_err_sticky", timeout_err, 1);
        compare_all("t4b");
        clear_err = 1'b1;
        @(negedge fabric_clk);
        clear_err = 1'b0;
        chk("t4_cleared", timeout_err, 0);
        // Second timeout with clear_err in the very cycle the flag is set
        m_never = 1'b1;
        push_cmd(LW'($urandom_range(1, 63)), $urandom, $urandom);
        wait_launches(1, "t4c");
        s = act_launch.size() > 0 ? act_launch[0].cyc : cyc;
        i = 0;
        while (cyc < s + TO - 1 && i < 100) begin
            @(negedge fabric_clk);
            i++;
        end
        chk("t4_before_second", timeout_err, 0);
        clear_err = 1'b1;
        @(negedge fabric_clk);
        clear_err = 1'b0;
        chk("t4_set_beats_clear", timeout_err, 1);
        settle("t4c");
        compare_all("t4c");
        m_never = 1'b0;
        clear_err = 1'b1;
        @(negedge fabric_clk);
        clear_err = 1'b0;
        chk("t4_cleared2", timeout_err, 0);

        // Zero-length command between two real ones
        m_busy_len = $urandom_range(2, 8);
        push_cmd(LW'($urandom_range(1, 63)), $urandom, $urandom);
        push_cmd(6'd0, $urandom, $urandom);
        push_cmd(LW'($urandom_range(1, 63)), $urandom, $urandom);
        settle("t5");
        chk("t5_two_launches", act_launch.size(), 2);
        chk("t5_two_rsps", act_rsp.size(), 2);
        compare_all("t5");

        // Reset during WAIT_DONE with two commands still queued
        m_busy_len = 40;
        for (int k = 0; k < 3; k++) push_cmd(LW'($urandom_range(1, 63)), $urandom, $urandom);
        wait_launches(1, "t6");
        repeat (5) @(negedge fabric_clk);
        chk("t6_busy_before_reset", spi_busy, 1);
        reset = 1'b1;
        @(negedge fabric_clk);
        chk_reset_vals("t6");
        @(negedge fabric_clk);
        reset = 1'b0;
        repeat (60) @(negedge fabric_clk);
        chk("t6_no_more_starts", act_launch.size(), 1);
        chk("t6_no_stale_rsp", act_rsp.size(), 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_idle", idle, 1);
        exp_launch.delete(); act_launch.delete(); exp_rsp.delete(); act_rsp.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
